// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive queue.
//               The PARITY state is always declared. The receiver only
//               enters it when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    typedef logic [7:0] byte_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : First-word-fall-through synchronous FIFO. The head entry is
//               always presented on o_data, and o_data reads as zero while
//               the FIFO is empty. A pop while empty is ignored. A push while
//               full is dropped and flagged on o_overrun, unless a pop in the
//               same cycle frees a slot.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot that a push into a full FIFO needs.
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_overrun = i_push & ~w_do_push;
    assign o_empty   = w_empty;
    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array. It needs no reset because the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth. The count tracks occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_queue
// Description : Oversampled UART receiver (x16), feeding a FWFT byte FIFO.
//               The default build receives 8N1 frames. Defining
//               UART_RX_PARITY_EN adds one even-parity bit per frame, and a
//               parity mismatch drops the byte and pulses o_parity_err.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_queue
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 96_000_000,
    parameter int BAUD   = 3_000_000,
    parameter int DEPTH  = 128
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_rx,
    input  logic  i_deq_rxq,
    output logic  o_rxq_empty,
    output byte_t o_rxq_data,
    output logic  o_overrun,
    output logic  o_frame_err,
    output logic  o_parity_err
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] c_DIV_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0] c_DIV_ONE   = DW'(1);
    localparam logic [3:0]    c_TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    c_TICK_LAST = 4'(OVERSAMPLE - 1);

    if ((DIV < 1) || ((CLK_HZ % (BAUD * OVERSAMPLE)) != 0)) begin : g_bad_div
        $error("uart_rx_queue: CLK_HZ/(BAUD*16) must be an integer >= 1");
    end

    rx_state_t     r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_div;
    logic          w_tick;
    logic [3:0]    r_tick;
    logic [2:0]    r_bit;
    byte_t         r_shift;
    logic          r_push;
    logic          r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bit;
    logic          r_parity_err;
`endif

    // The divider is held clear in IDLE, so each frame starts a fresh tick phase.
    assign w_tick = (r_state != IDLE) && (r_div == c_DIV_LAST);

    // Two-flop synchronizer. It resets high, so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Oversample divider. It gives one tick every DIV cycles, 16 ticks per bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if ((r_state == IDLE) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_ONE;
        end
    end

    // Receiver FSM. Push and error strobes are registered one-cycle pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!r_sync2) begin
                        r_tick  <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick == c_TICK_MID) begin
                            // Mid start bit. A high line here was a glitch.
                            r_tick  <= '0;
                            r_bit   <= '0;
                            r_state <= r_sync2 ? IDLE : DATA;
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        // The 4-bit counter wraps 15->0, re-arming for the next bit centre.
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == c_TICK_LAST) begin
                            r_shift <= {r_sync2, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == c_TICK_LAST) begin
                            r_par_bit <= r_sync2;
                            r_state   <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == c_TICK_LAST) begin
                            if (!r_sync2) begin
                                r_frame_err <= 1'b1;
                                r_state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                            end else if (r_par_bit != (^r_shift)) begin
                                r_parity_err <= 1'b1;
                                r_state      <= IDLE;
`endif
                            end else begin
                                r_push  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Hold here through a break so it reports only one frame error.
                    if (r_sync2) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (r_push),
        .i_data    (r_shift),
        .i_pop     (i_deq_rxq),
        .o_data    (o_rxq_data),
        .o_empty   (o_rxq_empty),
        .o_overrun (o_overrun)
    );

    assign o_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_queue
// Description : Scoreboard bench for uart_rx_queue. Driven frames push their
//               expected byte into a model queue. A drain process pops the
//               queue and compares against the DUT head as it dequeues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_queue;
    import uart_pkg::*;

    localparam int CLK_HZ  = 96_000_000;
    localparam int BAUD    = 3_000_000;
    localparam int DEPTH   = 128;
    localparam int BIT_CYC = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic  i_clk;
    logic  i_rst;
    logic  i_rx;
    logic  i_deq_rxq;
    logic  o_rxq_empty;
    byte_t o_rxq_data;
    logic  o_overrun;
    logic  o_frame_err;
    logic  o_parity_err;

    logic  deq_drain;
    logic  deq_force;
    logic  drain_en;
    assign i_deq_rxq = deq_drain | deq_force;

    int    n_checks  = 0;
    int    n_fail    = 0;
    int    exp_frame = 0;
    int    exp_par   = 0;
    int    exp_ovr   = 0;
    int    act_frame = 0;
    int    act_par   = 0;
    int    act_ovr   = 0;
    byte_t exp_q[$];

    uart_rx_queue #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .i_deq_rxq    (i_deq_rxq),
        .o_rxq_empty  (o_rxq_empty),
        .o_rxq_data   (o_rxq_data),
        .o_overrun    (o_overrun),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference FIFO: bounded queue, a byte arriving at a full queue is lost.
    function automatic void model_push(input byte_t b);
        if (exp_q.size() >= DEPTH) exp_ovr++;
        else exp_q.push_back(b);
    endfunction

    // Drive one frame, LSB first. The stop bit starts BIT_CYC*(9+parity) cycles in.
    // Offset 18 into the stop bit is just after the stop-centre sampling edge.
    task automatic send_frame(input byte_t b, input bit stop_ok, input int stop_len,
                              input bit bad_par, input bit chk_lat, input bit deq_at_push);
        byte_t head;
        head = 8'h00;
        if (deq_at_push) head = exp_q.pop_front();
        if (!stop_ok) exp_frame++;
        else if (bad_par && PAR_EN) exp_par++;
        else model_push(b);

        i_rx = 1'b0;
        repeat (BIT_CYC) @(posedge i_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (BIT_CYC) @(posedge i_clk);
            #1;
        end
        if (PAR_EN) begin
            i_rx = (^b) ^ bad_par;
            repeat (BIT_CYC) @(posedge i_clk);
            #1;
        end
        i_rx = stop_ok;
        for (int c = 0; c < BIT_CYC * stop_len; c++) begin
            @(posedge i_clk);
            #1;
            if (c == 18) begin
                if (chk_lat) check("latency_before_push", o_rxq_empty, 1);
                if (deq_at_push) begin
                    check("head_at_push", o_rxq_data, head);
                    deq_force = 1'b1;
                end
            end
            if (c == 19) begin
                deq_force = 1'b0;
                if (chk_lat) check("latency_after_push", o_rxq_empty, 0);
            end
        end
        if (!stop_ok) begin
            i_rx = 1'b1;
            repeat (BIT_CYC) @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_ok(input byte_t b);
        send_frame(b, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic deq_one();
        byte_t head;
        head = exp_q.pop_front();
        check("deq_head", o_rxq_data, head);
        deq_force = 1'b1;
        @(posedge i_clk);
        #1;
        deq_force = 1'b0;
    endtask

    task automatic drain_all(input string name);
        int n;
        n = 0;
        drain_en = 1'b1;
        while (((exp_q.size() != 0) || !o_rxq_empty) && (n < 2000)) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        drain_en = 1'b0;
        @(posedge i_clk);
        #1;
        check({name, "_drain_in_time"}, (n < 2000), 1);
        check({name, "_empty"}, o_rxq_empty, 1);
        check({name, "_model_left"}, exp_q.size(), 0);
    endtask

    task automatic check_errs(input string name);
        check({name, "_frame_err_cnt"}, act_frame, exp_frame);
        check({name, "_parity_err_cnt"}, act_par, exp_par);
        check({name, "_overrun_cnt"}, act_ovr, exp_ovr);
    endtask

    // Monitor: dequeue at random while enabled and compare each head against the model.
    initial begin
        deq_drain = 1'b0;
        forever begin
            @(negedge i_clk);
            deq_drain = 1'b0;
            if (drain_en && !o_rxq_empty && ($urandom_range(0, 3) != 0)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL drain_unexpected: got byte 0x%0h, expected none", o_rxq_data);
                end else begin
                    check("drain_data", o_rxq_data, exp_q.pop_front());
                end
                deq_drain = 1'b1;
            end
        end
    end

    // Pulse counters for the error strobes.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_frame_err === 1'b1) act_frame++;
            if (o_parity_err === 1'b1) act_par++;
            if (o_overrun === 1'b1) act_ovr++;
        end
    end

    initial begin
        #(95_000 * 10);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        byte_t b;
        i_rst     = 1'b1;
        i_rx      = 1'b1;
        deq_force = 1'b0;
        drain_en  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_empty", o_rxq_empty, 1);
        check("reset_data", o_rxq_data, 0);
        check("reset_frame_err", o_frame_err, 0);
        check("reset_parity_err", o_parity_err, 0);
        check("reset_overrun", o_overrun, 0);
        i_rst = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;

        // Single byte with exact push latency, then a dequeue.
        send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        check("a5_visible", o_rxq_data, 8'hA5);
        deq_one();
        check("a5_empty_after_deq", o_rxq_empty, 1);

        // Back-to-back frames with no idle gap.
        drain_en = 1'b1;
        send_ok(8'h00);
        send_ok(8'hFF);
        send_ok(8'h55);
        drain_all("b2b");
        check_errs("b2b");

        // Short low glitch on the idle line.
        i_rx = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        i_rx = 1'b1;
        repeat (4 * BIT_CYC) @(posedge i_clk);
        #1;
        check("glitch_empty", o_rxq_empty, 1);
        check_errs("glitch");
        send_ok(8'hC3);
        drain_all("after_glitch");

        // Break-like stop held low for three bit times, then recovery.
        send_frame(8'h3C, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        check("break_empty", o_rxq_empty, 1);
        check_errs("break");
        send_ok(8'h12);
        drain_all("after_break");

        // Random bytes with random idle gaps and random dequeue pacing.
        drain_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b = byte_t'($urandom);
            send_ok(b);
            repeat ($urandom_range(0, 40)) @(posedge i_clk);
            #1;
        end
        drain_all("random");
        check_errs("random");

        // Fill to DEPTH, overflow once, then push while full with a same-cycle deq.
        for (int k = 0; k < DEPTH; k++) begin
            b = byte_t'($urandom);
            send_ok(b);
        end
        send_ok(8'h77);
        check_errs("overrun");
        check("head_after_overrun", o_rxq_data, exp_q[0]);
        send_frame(8'h5A, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        check_errs("full_push_deq");
        drain_all("full");

        // Asynchronous reset mid-frame discards queued bytes.
        for (int k = 0; k < 5; k++) send_ok(byte_t'(8'h30 + k));
        i_rx = 1'b0;
        repeat (3 * BIT_CYC) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        check("async_reset_empty", o_rxq_empty, 1);
        check("async_reset_data", o_rxq_data, 0);
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rx  = 1'b1;
        i_rst = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        send_ok(8'h81);
        drain_all("after_reset");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x81 needs parity bit 0. A frame error masks a parity error.
        send_frame(8'h81, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        check("bad_parity_empty", o_rxq_empty, 1);
        check_errs("bad_parity");
        send_frame(8'h81, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        check_errs("frame_over_parity");
        send_ok(8'h81);
        drain_all("good_parity");
`endif

        check_errs("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_queue.md
Name: uart_rx_queue

Overview:
- Receive front end for the host link: oversampled UART receiver plus a byte FIFO.
- Serialises nothing; deserialises 8N1 frames from the host pin and queues the bytes.
- Presents a first-word-fall-through dequeue interface (empty/data/deq) that the downstream packet arbiter drains one byte per cycle.
- Depth covers one full DC payload (124 bytes plus channel header) without backpressure.

Parameters:
- CLK_HZ, 96_000_000, system clock frequency.
- BAUD, 3_000_000, line rate.
- DEPTH, 128, FIFO entries; power of two, at least 2.
- Derived, not overridable: DIV = CLK_HZ/(BAUD*16), integer and at least 1 (elaboration error otherwise); AW = $clog2(DEPTH).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_rx  input  1  asynchronous serial line, idle high
- i_deq_rxq  input  1  dequeue head byte this cycle
- o_rxq_empty  output  1  FIFO empty; o_rxq_data invalid when high
- o_rxq_data  output  8  head byte (FWFT)
- o_overrun  output  1  one-cycle pulse: byte received while FIFO full, byte dropped
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte dropped
- o_parity_err  output  1  one-cycle pulse: parity mismatch, byte dropped (0 unless macro)

Behaviour:
- Reset:
  - Synchronizer flops reset to 1; FSM reset to IDLE; FIFO pointers and count reset to 0.
  - o_rxq_empty=1, o_rxq_data=0, all error pulses 0.
  - Reset asserted mid-frame or mid-FIFO discards everything.
- Input sync: i_rx passes through a 2-flop synchronizer; the FSM uses only the synchronized value.
- Tick gen:
  - Counter 0..DIV-1 produces a 1-cycle tick at DIV-1, giving 16 ticks per bit.
  - It runs only while the FSM is outside IDLE and is cleared on entry to START.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH; a 4-bit tick counter and a 3-bit bit counter.
  - IDLE: synchronized rx low -> START.
  - START: at tick 7 (mid start bit), rx high -> IDLE (glitch reject, no error); rx low -> clear tick counter, go to DATA.
  - DATA: sample every 16 ticks (bit centre), shift in LSB first; after bit 7 -> STOP.
  - STOP: at 16 ticks, rx high -> push byte, go to IDLE; rx low -> o_frame_err pulse, no push, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx high, then IDLE. A break condition therefore yields exactly one frame error.
- FIFO, first-word fall-through:
  - A push in cycle N makes the byte visible and deasserts o_rxq_empty in cycle N+1.
  - Deq while empty is ignored.
  - Push while full drops the byte and pulses o_overrun in the same cycle as the attempted push.
  - Push and deq in the same cycle while full: both take effect and the count is unchanged.
  - Push and deq in the same cycle while empty: the deq is ignored, the push lands, and the count becomes 1.
  - Pointers are AW bits and wrap naturally; count is AW+1 bits.
- Latency: stop-bit centre sample to o_rxq_empty low is 2 cycles (push register plus FIFO write), excluding the 2-flop sync.
- Back-to-back frames: a new start bit can be detected in the cycle after leaving STOP, so continuous streaming at BAUD loses no bytes.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a state PARITY between DATA and STOP that samples one even-parity bit.
  - On mismatch, o_parity_err pulses at the stop-bit sample and the byte is not pushed.
  - A frame error takes precedence: only o_frame_err pulses.
- Undefined: the frame is 8N1, there is no PARITY state, and o_parity_err is tied 0.

Decomposition:
- Package uart_pkg holds:
  - OVERSAMPLE=16;
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}, with PARITY present regardless of the macro;
  - typedef logic [7:0] byte_t.
- One sub-module: byte_fifo (parameters DEPTH, WIDTH=8), a FWFT synchronous FIFO with the push/pop/full/empty semantics above. The receiver FSM stays in uart_rx_queue.

Test Plan:
- Default params (DIV=2); send 0xA5 as 8N1 -> o_rxq_data=0xA5 with o_rxq_empty low 2 cycles after the stop-centre sample; deq -> empty high the next cycle.
- Send 0x00, 0xFF, 0x55 back-to-back with no idle -> three bytes dequeued in order; no error pulses.
- 10-cycle low glitch on idle line (shorter than half a bit, 16 cycles) -> no push, FSM back in IDLE, no error.
- Send 0x3C with the stop bit held low for 3 bit times -> exactly one o_frame_err pulse, FIFO stays empty; a following 0x12 is received correctly.
- Fill 128 bytes without deq, then send 0x77 -> one o_overrun pulse, count stays 128; head byte is still byte 0.
- Same test, but deq asserted during the 129th push -> the 0x77 is accepted and the count stays 128.
- Reset asserted mid-DATA with 5 bytes queued -> o_rxq_empty=1 immediately (async); next frame 0x81 is received cleanly.
- With UART_RX_PARITY_EN: 0x81 sent with parity 1 -> o_parity_err pulse and no push; sent with parity 0 -> pushed.
